// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with registered read ports, write-to-read
// bypass, synchronous bulk clear, optional hard-wired zero register and a written mask.
module regfile_2r1w #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int SEL_W    = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic [SEL_W-1:0] write_sel,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear,
    input  logic             rd_en_a,
    input  logic [SEL_W-1:0] read_sel_a,
    output logic [WIDTH-1:0] data_out_a,
    output logic             valid_a,
    input  logic             rd_en_b,
    input  logic [SEL_W-1:0] read_sel_b,
    output logic [WIDTH-1:0] data_out_b,
    output logic             valid_b,
    output logic [DEPTH-1:0] written
);

    localparam int NPORTS = 2;
    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [SEL_W:0] DEPTH_L = (SEL_W + 1)'(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] written_q;
    logic [DEPTH-1:0] written_d;
    logic             wr_ok;

    // A write that actually lands: in range, and not aimed at the hard-wired zero entry.
    assign wr_ok = write_en
                && ({1'b0, write_sel} < DEPTH_L)
                && !(ZERO_REG && (write_sel == '0));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [SEL_W-1:0] IDX = SEL_W'(gi);
            logic hit;

            assign hit           = wr_ok && (write_sel == IDX);
            assign regs_d[gi]    = clear ? '0   : (hit ? data_in : regs_q[gi]);
            assign written_d[gi] = clear ? 1'b0 : (hit ? 1'b1    : written_q[gi]);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            written_q <= '0;
        end else begin
            written_q <= written_d;
        end
    end

    assign written = written_q;

    logic             rd_en_w  [NPORTS];
    logic [SEL_W-1:0] rd_sel_w [NPORTS];
    logic [WIDTH-1:0] rd_val   [NPORTS];
    logic [WIDTH-1:0] dout_d   [NPORTS];
    logic [WIDTH-1:0] dout_q   [NPORTS];
    logic             valid_q  [NPORTS];

    assign rd_en_w[0]  = rd_en_a;
    assign rd_en_w[1]  = rd_en_b;
    assign rd_sel_w[0] = read_sel_a;
    assign rd_sel_w[1] = read_sel_b;

    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            logic in_range;
            logic is_zero;
            logic bypass;

            assign in_range = ({1'b0, rd_sel_w[gi]} < DEPTH_L);
            assign is_zero  = ZERO_REG && (rd_sel_w[gi] == '0);
            assign bypass   = wr_ok && (write_sel == rd_sel_w[gi]);

            // Clear wins over bypass; ignored writes never bypass because wr_ok excludes them.
            always_comb begin
                rd_val[gi] = '0;
                if (clear || !in_range || is_zero) begin
                    rd_val[gi] = '0;
                end else if (bypass) begin
                    rd_val[gi] = data_in;
                end else begin
                    rd_val[gi] = regs_q[rd_sel_w[gi]];
                end
            end

            assign dout_d[gi] = rd_en_w[gi] ? rd_val[gi] : dout_q[gi];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dout_q[gi]  <= '0;
                    valid_q[gi] <= 1'b0;
                end else begin
                    dout_q[gi]  <= dout_d[gi];
                    valid_q[gi] <= rd_en_w[gi];
                end
            end
        end
    endgenerate

    assign data_out_a = dout_q[0];
    assign valid_a    = valid_q[0];
    assign data_out_b = dout_q[1];
    assign valid_b    = valid_q[1];

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: a default 8-entry instance and a 6-entry
// ZERO_REG instance share one stimulus stream and are checked against an array model.
module tb_regfile_2r1w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       write_en;
    logic [2:0] write_sel;
    logic [7:0] data_in;
    logic       clear;
    logic       rd_en_a;
    logic [2:0] read_sel_a;
    logic       rd_en_b;
    logic [2:0] read_sel_b;

    logic [7:0] d0a, d0b, d1a, d1b;
    logic       v0a, v0b, v1a, v1b;
    logic [7:0] wr0;
    logic [5:0] wr1;

    regfile_2r1w dut0 (
        .clk(clk), .reset(reset), .write_en(write_en), .write_sel(write_sel),
        .data_in(data_in), .clear(clear),
        .rd_en_a(rd_en_a), .read_sel_a(read_sel_a), .data_out_a(d0a), .valid_a(v0a),
        .rd_en_b(rd_en_b), .read_sel_b(read_sel_b), .data_out_b(d0b), .valid_b(v0b),
        .written(wr0)
    );

    regfile_2r1w #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1'b1)) dut1 (
        .clk(clk), .reset(reset), .write_en(write_en), .write_sel(write_sel),
        .data_in(data_in), .clear(clear),
        .rd_en_a(rd_en_a), .read_sel_a(read_sel_a), .data_out_a(d1a), .valid_a(v1a),
        .rd_en_b(rd_en_b), .read_sel_b(read_sel_b), .data_out_b(d1b), .valid_b(v1b),
        .written(wr1)
    );

    logic [7:0] dout [4];
    logic       vld  [4];
    always_comb begin
        dout[0] = d0a; dout[1] = d0b; dout[2] = d1a; dout[3] = d1b;
        vld[0]  = v0a; vld[1]  = v0b; vld[2]  = v1a; vld[3]  = v1b;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } rd_exp_t;

    // Scoreboard: front entry is the output state expected after the most recent edge.
    rd_exp_t    exp_q  [4][$];
    logic [7:0] wexp_q [2][$];

    // Reference model: register contents, written masks, last data returned per port.
    logic [7:0] mem   [2][8];
    logic [7:0] wmask [2];
    logic [7:0] last  [4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
            last[i] = 8'h00;
            exp_q[i].push_back({1'b0, 8'h00});
        end
        for (int k = 0; k < 2; k++) begin
            wexp_q[k].delete();
            wmask[k] = 8'h00;
            for (int i = 0; i < 8; i++) mem[k][i] = 8'h00;
            wexp_q[k].push_back(8'h00);
        end
    endtask

    task automatic idle_inputs();
        write_en = 0; write_sel = 0; data_in = 0; clear = 0;
        rd_en_a = 0; read_sel_a = 0; rd_en_b = 0; read_sel_b = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic do_cycle(input bit we, input int ws, input logic [7:0] din, input bit clr,
                            input bit ea, input int sa, input bit eb, input int sb);
        int         d;
        bit         z;
        bit         vw;
        bit         e;
        int         s;
        logic [7:0] v;
        write_en = we; write_sel = ws[2:0]; data_in = din; clear = clr;
        rd_en_a = ea; read_sel_a = sa[2:0]; rd_en_b = eb; read_sel_b = sb[2:0];
        for (int k = 0; k < 2; k++) begin
            d  = (k == 1) ? 6 : 8;
            z  = (k == 1);
            vw = we && (ws < d) && !(z && ws == 0);
            for (int p = 0; p < 2; p++) begin
                e = (p == 1) ? eb : ea;
                s = (p == 1) ? sb : sa;
                if (e) begin
                    if (clr || s >= d || (z && s == 0)) v = 8'h00;
                    else if (vw && ws == s)             v = din;
                    else                                v = mem[k][s];
                    last[k*2+p] = v;
                end
                exp_q[k*2+p].push_back({e, last[k*2+p]});
            end
            if (clr) begin
                for (int i = 0; i < 8; i++) mem[k][i] = 8'h00;
                wmask[k] = 8'h00;
            end else if (vw) begin
                mem[k][ws]   = din;
                wmask[k][ws] = 1'b1;
            end
            wexp_q[k].push_back(wmask[k]);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            for (int i = 0; i < 4; i++) begin
                if (exp_q[i].size() > 0) begin
                    rd_exp_t ex;
                    ex = exp_q[i].pop_front();
                    chk($sformatf("valid[%0d]", i), {31'd0, vld[i]}, {31'd0, ex.v});
                    chk($sformatf("data[%0d]", i), {24'd0, dout[i]}, {24'd0, ex.d});
                end
            end
            if (wexp_q[0].size() > 0) chk("written0", {24'd0, wr0}, {24'd0, wexp_q[0].pop_front()});
            if (wexp_q[1].size() > 0) chk("written1", {26'd0, wr1}, {24'd0, wexp_q[1].pop_front()});
        end
    end

    initial begin
        do_reset();

        // Read after reset.
        do_cycle(0, 0, 8'h00, 0, 1, 4, 0, 0);
        chk("rst_read_data", {24'd0, d0a}, 32'h0);
        chk("rst_read_valid", {31'd0, v0a}, 32'h1);
        chk("rst_written", {24'd0, wr0}, 32'h00);

        // Write then dual read of the same register.
        do_cycle(1, 5, 8'd9, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 8'h00, 0, 1, 5, 1, 5);
        chk("dual_read_a", {24'd0, d0a}, 32'd9);
        chk("dual_read_b", {24'd0, d0b}, 32'd9);
        chk("written_r5", {24'd0, wr0}, 32'h20);

        // Bypass, then normal read on B.
        do_cycle(1, 2, 8'd6, 0, 1, 2, 0, 0);
        chk("bypass_a", {24'd0, d0a}, 32'd6);
        do_cycle(0, 0, 8'h00, 0, 0, 0, 1, 2);
        chk("after_bypass_b", {24'd0, d0b}, 32'd6);

        // Clear beats same-cycle write and read.
        do_cycle(1, 5, 8'd10, 1, 1, 5, 0, 0);
        chk("clear_read_a", {24'd0, d0a}, 32'd0);
        chk("clear_valid_a", {31'd0, v0a}, 32'h1);
        chk("clear_written", {24'd0, wr0}, 32'h00);
        do_cycle(0, 0, 8'h00, 0, 1, 5, 0, 0);
        chk("post_clear_r5", {24'd0, d0a}, 32'd0);

        // Zero register and out-of-range accesses on the 6-entry instance.
        do_cycle(1, 0, 8'd3, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 8'h00, 0, 1, 0, 0, 0);
        chk("zero_reg_read", {24'd0, d1a}, 32'd0);
        chk("zero_reg_written", {31'd0, wr1[0]}, 32'd0);
        chk("r0_normal_read", {24'd0, d0a}, 32'd3);
        do_cycle(1, 7, 8'h55, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 8'h00, 0, 1, 7, 1, 7);
        chk("oor_read_data", {24'd0, d1a}, 32'd0);
        chk("oor_read_valid", {31'd0, v1a}, 32'h1);
        chk("oor_written", {26'd0, wr1}, 32'h00);
        chk("r7_normal_read", {24'd0, d0b}, 32'h55);

        // Asynchronous reset mid-cycle.
        do_cycle(1, 5, 8'd9, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 8'h00, 0, 1, 5, 0, 0);
        chk("pre_rst_valid", {31'd0, v0a}, 32'h1);
        chk("pre_rst_data", {24'd0, d0a}, 32'd9);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, v0a}, 32'h0);
        chk("async_rst_data", {24'd0, d0a}, 32'h0);
        chk("async_rst_written", {24'd0, wr0}, 32'h0);
        do_reset();
        do_cycle(0, 0, 8'h00, 0, 1, 5, 1, 2);
        chk("post_rst_r5", {24'd0, d0a}, 32'h0);
        chk("post_rst_r2", {24'd0, d0b}, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            do_cycle($urandom_range(0, 1), $urandom_range(0, 7), 8'($urandom),
                     ($urandom_range(0, 15) == 0),
                     $urandom_range(0, 1), $urandom_range(0, 7),
                     $urandom_range(0, 1), $urandom_range(0, 7));
        end
        idle_inputs();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
